// File: rtl/button_conditioner.sv
// Four-lane push-button front end: polarity correction, 2-flop synchroniser,
// per-lane debounce FSM with registered level, press/release and long-press strobes.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LONG_CYCLES     = 12500000,
    parameter int CNT_W           = 24,
    parameter int RAW_ACTIVE_LOW  = 0
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    output logic       button_r,
    output logic       button_b,
    output logic       button_c,
    output logic       button_h,
    output logic [3:0] press_pulse,
    output logic [3:0] release_pulse,
    output logic [3:0] long_press
);

    localparam logic [1:0] S_UP     = 2'd0;
    localparam logic [1:0] S_DN_CHK = 2'd1;
    localparam logic [1:0] S_DN     = 2'd2;
    localparam logic [1:0] S_UP_CHK = 2'd3;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Entry register (after polarity correction) followed by the 2-flop synchroniser.
    logic [3:0] in_q, in_d;
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] s;

    logic [1:0]       state_q [0:3];
    logic [1:0]       state_d [0:3];
    logic [CNT_W-1:0] dcnt_q  [0:3];
    logic [CNT_W-1:0] dcnt_d  [0:3];
    logic [CNT_W-1:0] hcnt_q  [0:3];
    logic [CNT_W-1:0] hcnt_d  [0:3];

    logic [3:0] level_q, level_d;
    logic [3:0] press_q, press_d;
    logic [3:0] release_q, release_d;
    logic [3:0] long_q, long_d;

    always_comb begin
        in_d    = (RAW_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
        sync1_d = in_q;
        sync2_d = sync1_q;
        s       = sync2_q;

        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;

        for (int unsigned i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            dcnt_d[i]  = dcnt_q[i];
            hcnt_d[i]  = hcnt_q[i];

            // Hold time keeps running through a release check so a brief
            // dropout neither restarts nor re-arms the long-press strobe.
            if ((state_q[i] == S_DN || state_q[i] == S_UP_CHK) && hcnt_q[i] != LONG_MAX) begin
                hcnt_d[i] = hcnt_q[i] + CNT_ONE;
                long_d[i] = (hcnt_q[i] == LONG_LAST);
            end

            case (state_q[i])
                S_UP: begin
                    if (s[i]) begin
                        state_d[i] = S_DN_CHK;
                        dcnt_d[i]  = '0;
                    end
                end
                S_DN_CHK: begin
                    if (!s[i]) begin
                        state_d[i] = S_UP;
                    end else if (dcnt_q[i] == DEB_LAST) begin
                        state_d[i] = S_DN;
                        level_d[i] = 1'b1;
                        press_d[i] = 1'b1;
                        hcnt_d[i]  = '0;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + CNT_ONE;
                    end
                end
                S_DN: begin
                    if (!s[i]) begin
                        state_d[i] = S_UP_CHK;
                        dcnt_d[i]  = '0;
                    end
                end
                S_UP_CHK: begin
                    if (s[i]) begin
                        state_d[i] = S_DN;
                    end else if (dcnt_q[i] == DEB_LAST) begin
                        state_d[i]   = S_UP;
                        level_d[i]   = 1'b0;
                        release_d[i] = 1'b1;
                        hcnt_d[i]    = '0;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = S_UP;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            in_q      <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= S_UP;
                dcnt_q[i]  <= '0;
                hcnt_q[i]  <= '0;
            end
        end else begin
            in_q      <= in_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                dcnt_q[i]  <= dcnt_d[i];
                hcnt_q[i]  <= hcnt_d[i];
            end
        end
    end

    assign button_r      = level_q[0];
    assign button_b      = level_q[1];
    assign button_c      = level_q[2];
    assign button_h      = level_q[3];
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;

endmodule
